// File: rtl/run_code_scheduler.sv
// Frames each parallel word as 0, data bits LSB-first, 0 and streams it to the serial
// run-length detector, tallying the run codes it returns into three result counters.
module run_code_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             det_x,
    input  logic [1:0]       det_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_run1,
    output logic [CNT_W-1:0] cnt_run2,
    output logic [CNT_W-1:0] cnt_run3p,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        TERM,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             detx_q, detx_d;
    logic [CNT_W-1:0] run1_q, run1_d;
    logic [CNT_W-1:0] run2_q, run2_d;
    logic [CNT_W-1:0] run3p_q, run3p_d;
    logic             sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
            detx_q  <= 1'b0;
            run1_q  <= '0;
            run2_q  <= '0;
            run3p_q <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            detx_q  <= detx_d;
            run1_q  <= run1_d;
            run2_q  <= run2_d;
            run3p_q <= run3p_d;
        end
    end

    // The code arriving in DATA cycle 1 belongs to the preamble, so sampling starts one bit late
    // and runs through DRAIN to catch the run closed by the terminator.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        run1_d  = run1_q;
        run2_d  = run2_q;
        run3p_d = run3p_q;
        sample  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = in_data;
                    idx_d   = '0;
                    run1_d  = '0;
                    run2_d  = '0;
                    run3p_d = '0;
                    state_d = PRE;
                end
            end
            PRE: state_d = DATA;
            DATA: begin
                sreg_d = sreg_q >> 1;
                idx_d  = idx_q + IDX_W'(1);
                sample = (idx_q != '0);
                if (idx_q == LAST_IDX) begin
                    state_d = TERM;
                end
            end
            TERM: begin
                sample  = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                sample  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sample) begin
            case (det_y)
                2'b01: if (run1_q != CNT_MAX) run1_d = run1_q + CNT_W'(1);
                2'b10: if (run2_q != CNT_MAX) run2_d = run2_q + CNT_W'(1);
                2'b11: if (run3p_q != CNT_MAX) run3p_d = run3p_q + CNT_W'(1);
                default: ;
            endcase
        end

        detx_d = (state_d == DATA) ? sreg_d[0] : 1'b0;
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign det_x     = detx_q;
    assign cnt_run1  = run1_q;
    assign cnt_run2  = run2_q;
    assign cnt_run3p = run3p_q;

endmodule

// File: tb/tb_run_code_scheduler.sv
// Drives run_code_scheduler against a model of the serial run-length detector and checks
// tallies, latency, serial framing and handshakes against a word-level run-count model.
module tb_run_code_scheduler;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;
    logic             detX;
    logic [1:0]       detY = 2'b00;
    logic             outValid;
    logic             outReady;
    logic [CNT_W-1:0] cntRun1;
    logic [CNT_W-1:0] cntRun2;
    logic [CNT_W-1:0] cntRun3p;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;
    int detRun     = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               hold;
        int               exp1;
        int               exp2;
        int               exp3;
    } vector_t;

    vector_t vectors[5];

    run_code_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .det_x     (detX),
        .det_y     (detY),
        .out_valid (outValid),
        .out_ready (outReady),
        .cnt_run1  (cntRun1),
        .cnt_run2  (cntRun2),
        .cnt_run3p (cntRun3p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Detector: a 0 following a run reports its length class on the next cycle; it has no reset.
    always @(posedge clk) begin
        if (detX) begin
            detRun <= (detRun < 3) ? detRun + 1 : 3;
            detY   <= 2'b00;
        end else begin
            detY   <= 2'(detRun);
            detRun <= 0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void runModel(input logic [WIDTH-1:0] d, output int r1, output int r2, output int r3);
        int run;
        run = 0;
        r1  = 0;
        r2  = 0;
        r3  = 0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (i < WIDTH && d[i]) begin
                run++;
            end else begin
                if (run == 1) r1++;
                else if (run == 2) r2++;
                else if (run >= 3) r3++;
                run = 0;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input int hold, input int e1, input int e2, input int e3);
        int lat;
        int guard;
        guard = 0;
        while (!inReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("in_ready before accept", int'(inReady), 1);
        inValid = 1'b1;
        inData  = d;
        @(negedge clk);
        inValid = 1'b0;
        inData  = WIDTH'($urandom);
        checkOutput("busy after accept", int'(busy), 1);
        lat = 0;
        while (!outValid && lat < 40) begin
            checkOutput("det_x framing", int'(detX), (lat >= 1 && lat <= WIDTH) ? int'(d[lat-1]) : 0);
            inValid = 1'($urandom);
            inData  = WIDTH'($urandom);
            @(negedge clk);
            lat++;
        end
        inValid = 1'b0;
        checkOutput("out_valid latency", lat, WIDTH + 3);
        checkOutput("cnt_run1", int'(cntRun1), e1);
        checkOutput("cnt_run2", int'(cntRun2), e2);
        checkOutput("cnt_run3p", int'(cntRun3p), e3);
        for (int h = 0; h < hold; h++) begin
            inValid = 1'($urandom);
            inData  = WIDTH'($urandom);
            @(negedge clk);
            checkOutput("out_valid held", int'(outValid), 1);
            checkOutput("in_ready in DONE", int'(inReady), 0);
            checkOutput("cnt_run1 held", int'(cntRun1), e1);
            checkOutput("cnt_run2 held", int'(cntRun2), e2);
            checkOutput("cnt_run3p held", int'(cntRun3p), e3);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("out_valid after accept", int'(outValid), 0);
        checkOutput("in_ready after accept", int'(inReady), 1);
        checkOutput("cnt_run2 kept in IDLE", int'(cntRun2), e2);
    endtask

    initial begin
        int r1, r2, r3;
        bit sawValid;

        vectors[0] = '{data: 8'h06, hold: 0, exp1: 0, exp2: 1, exp3: 0};
        vectors[1] = '{data: 8'hFF, hold: 0, exp1: 0, exp2: 0, exp3: 1};
        vectors[2] = '{data: 8'h55, hold: 0, exp1: 4, exp2: 0, exp3: 0};
        vectors[3] = '{data: 8'h00, hold: 0, exp1: 0, exp2: 0, exp3: 0};
        vectors[4] = '{data: 8'hB6, hold: 5, exp1: 1, exp2: 2, exp3: 0};

        rst      = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", int'(inReady), 1);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset out_valid", int'(outValid), 0);
        checkOutput("reset det_x", int'(detX), 0);
        checkOutput("reset counters", int'({cntRun1, cntRun2, cntRun3p}), 0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].data, vectors[i].hold, vectors[i].exp1, vectors[i].exp2, vectors[i].exp3);
        end

        // Abort 8'hFF with an async reset while DATA bit 3 is on the wire.
        inValid = 1'b1;
        inData  = 8'hFF;
        @(negedge clk);
        inValid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("det_x at bit 3 before abort", int'(detX), 1);
        rst = 1'b0;
        #1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort in_ready", int'(inReady), 1);
        checkOutput("abort det_x", int'(detX), 0);
        checkOutput("abort out_valid", int'(outValid), 0);
        @(negedge clk);
        rst = 1'b1;
        sawValid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (outValid) sawValid = 1'b1;
        end
        checkOutput("no result after abort", int'(sawValid), 0);
        applyStimulus(8'h06, 0, 0, 1, 0);

        for (int n = 0; n < 30; n++) begin
            logic [WIDTH-1:0] d;
            d = WIDTH'($urandom);
            runModel(d, r1, r2, r3);
            applyStimulus(d, int'($urandom_range(0, 3)), r1, r2, r3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
